// File: rtl/st7920_gfx_streamer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : st7920_pkg                                                      |
// | Purpose  : Shared types and constants for the ST7920 graphics streamer:    |
// |            FSM state encodings, LCD command bytes, the serial sync header  |
// |            and a helper that assembles the 24-bit serial frame.            |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package st7920_pkg;

    // Frame-level sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SET_Y = 3'd2,
        S_SET_X = 3'd3,
        S_FETCH = 3'd4,
        S_DATA  = 3'd5,
        S_FLUSH = 3'd6,   // last byte handed off, waiting for the wire to go quiet
        S_DONE  = 3'd7
    } gfx_state_t;

    // Serial shifter states
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_SETUP = 3'd1,
        TX_LOW   = 3'd2,
        TX_HIGH  = 3'd3,
        TX_GAP   = 3'd4
    } tx_state_t;

    localparam logic [7:0] CMD_FUNC_BASIC = 8'h30;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_FUNC_EXT   = 8'h34;
    localparam logic [7:0] CMD_GFX_ON     = 8'h36;
    localparam logic [7:0] CMD_ADDR       = 8'h80;

    localparam logic [4:0] SYNC_HDR   = 5'b11111;
    localparam int         FRAME_BITS = 24;

    // 11111, RW=0, RS, 0, D7..D4, 0000, D3..D0, 0000 (MSB first on the wire)
    function automatic logic [23:0] build_frame(input logic rs, input logic [7:0] data);
        return {SYNC_HDR, 1'b0, rs, 1'b0, data[7:4], 4'b0000, data[3:0], 4'b0000};
    endfunction

    // Power-up command list, sent once after reset before the first frame
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_BASIC;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_FUNC_EXT;
            default: cmd = CMD_GFX_ON;
        endcase
        return cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/st7920_gfx_streamer_if.sv
// +----------------------------------------------------------------------------+
// | Module   : st7920_gfx_streamer_if                                          |
// | Purpose  : Bundles the controller handshake, framebuffer read port and     |
// |            LCD serial pins of the graphics streamer.                       |
// | Ports    : start_frame, busy, frame_done    - controller handshake        |
// |            fb_rd_en, fb_addr, fb_rd_data     - framebuffer read port       |
// |            lcd_cs, lcd_sclk, lcd_sid         - ST7920 serial pins          |
// |            modport slave  : streamer side                                  |
// |            modport master : controller / RAM / panel side                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface st7920_gfx_streamer_if #(
    parameter int FB_AW = 10
);
    logic             start_frame;
    logic             busy;
    logic             frame_done;
    logic             fb_rd_en;
    logic [FB_AW-1:0] fb_addr;
    logic [7:0]       fb_rd_data;
    logic             lcd_cs;
    logic             lcd_sclk;
    logic             lcd_sid;

    modport slave (
        input  start_frame, fb_rd_data,
        output busy, frame_done, fb_rd_en, fb_addr, lcd_cs, lcd_sclk, lcd_sid
    );

    modport master (
        output start_frame, fb_rd_data,
        input  busy, frame_done, fb_rd_en, fb_addr, lcd_cs, lcd_sclk, lcd_sid
    );
endinterface

`default_nettype wire

// File: rtl/st7920_gfx_streamer_serial_tx.sv
// +----------------------------------------------------------------------------+
// | Module   : st7920_serial_tx                                                |
// | Purpose  : Shifts one 24-bit ST7920 serial frame per accepted byte and     |
// |            enforces the inter-command gap.                                 |
// | Ports    : clk, rst            - clock, synchronous active-high reset      |
// |            tx_valid/tx_ready   - byte handshake (ready only when idle)     |
// |            tx_rs, tx_data      - register select and payload byte          |
// |            lcd_cs/sclk/sid     - registered serial pins                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module st7920_serial_tx
    import st7920_pkg::*;
#(
    parameter int CLK_DIV     = 256,
    parameter int CMD_GAP_CYC = 1024
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_rs,
    input  logic [7:0] tx_data,
    output logic       lcd_cs,
    output logic       lcd_sclk,
    output logic       lcd_sid
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CMD_GAP_CYC > 1) ? $clog2(CMD_GAP_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CMD_GAP_CYC > 0) ? CMD_GAP_CYC - 1 : 0);
    localparam logic [4:0]       BIT_LAST = 5'(FRAME_BITS - 1);

    tx_state_t        state;
    logic [23:0]      shreg;
    logic [4:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;

    assign tx_ready = (state == TX_IDLE);

    // SID is the MSB of the shift register, so it is a flop output and only
    // moves on the same edge that drives SCLK low.
    assign lcd_sid = shreg[23];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            lcd_cs   <= 1'b0;
            lcd_sclk <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        shreg   <= build_frame(tx_rs, tx_data);
                        lcd_cs  <= 1'b1;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= TX_SETUP;
                    end
                end
                // One cycle of CS high with SCLK low before the first low phase
                TX_SETUP: state <= TX_LOW;
                TX_LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        lcd_sclk <= 1'b1;
                        state    <= TX_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TX_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        lcd_sclk <= 1'b0;
                        shreg    <= {shreg[22:0], 1'b0};
                        if (bit_cnt == BIT_LAST) begin
                            lcd_cs  <= 1'b0;
                            gap_cnt <= '0;
                            state   <= (CMD_GAP_CYC > 0) ? TX_GAP : TX_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= TX_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TX_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= TX_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/st7920_gfx_streamer.sv
// +----------------------------------------------------------------------------+
// | Module   : st7920_gfx_streamer                                             |
// | Purpose  : Streams a framebuffer from a 1-cycle-latency read port to an    |
// |            ST7920 graphic LCD over its 3-wire serial link. Runs the init   |
// |            sequence on the first frame after reset, folds tall panels      |
// |            into GDRAM lines, and offers a start/busy/done handshake.       |
// | Ports    : sys_clk, sys_rst - clock, synchronous active-high reset         |
// |            bus (slave)      - start_frame/busy/frame_done, fb_rd_en/       |
// |                               fb_addr/fb_rd_data, lcd_cs/lcd_sclk/lcd_sid  |
// | Options  : ST7920_AUTO_REFRESH_EN - self-start REFRESH_CYC cycles after    |
// |            each frame_done                                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module st7920_gfx_streamer
    import st7920_pkg::*;
#(
    parameter int CLK_DIV     = 256,
    parameter int CMD_GAP_CYC = 1024,
    parameter int COLS_BYTES  = 16,
    parameter int ROWS        = 64,
    parameter int FOLD        = 1
`ifdef ST7920_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYC = 2_000_000
`endif
)(
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    st7920_gfx_streamer_if.slave bus
);

    localparam int LINES  = (FOLD != 0) ? ROWS / 2 : ROWS;
    localparam int BPL    = (FOLD != 0) ? 2 * COLS_BYTES : COLS_BYTES;
    localparam int FB_AW  = (ROWS * COLS_BYTES > 1) ? $clog2(ROWS * COLS_BYTES) : 1;
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int BPL_W  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [BPL_W-1:0]  BPL_LAST  = BPL_W'(BPL - 1);

    gfx_state_t        state;
    logic              init_done;
    logic [1:0]        init_idx;
    logic [LINE_W-1:0] line;
    logic [BPL_W-1:0]  col;
    logic [7:0]        data_q;
    logic              captured;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic [FB_AW-1:0]  addr_q;

    logic              tx_valid;
    logic              tx_ready;
    logic              tx_rs;
    logic [7:0]        tx_data;
    logic              tx_fire;
    logic              start_req;

    // Folded panels append the lower half-row to each GDRAM line: columns
    // past COLS_BYTES map to row line+ROWS/2.
    function automatic logic [FB_AW-1:0] byte_addr(input logic [LINE_W-1:0] ln,
                                                   input logic [BPL_W-1:0]  cl);
        logic [FB_AW-1:0] row;
        logic [FB_AW-1:0] colb;
        row  = FB_AW'(ln);
        colb = FB_AW'(cl);
        if ((FOLD != 0) && (int'(cl) >= COLS_BYTES)) begin
            row  = row + FB_AW'(ROWS / 2);
            colb = colb - FB_AW'(COLS_BYTES);
        end
        return row * FB_AW'(COLS_BYTES) + colb;
    endfunction

`ifdef ST7920_AUTO_REFRESH_EN
    logic        refresh_armed;
    logic [31:0] refresh_cnt;
    logic        auto_start;

    // refresh_cnt equals the number of cycles elapsed since frame_done
    assign auto_start = refresh_armed && (refresh_cnt == 32'(REFRESH_CYC));
    assign start_req  = bus.start_frame || auto_start;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            refresh_armed <= 1'b0;
            refresh_cnt   <= '0;
        end else if ((state == S_IDLE) && start_req) begin
            // Any accepted start, external or automatic, disarms until the
            // next frame_done re-arms from zero.
            refresh_armed <= 1'b0;
            refresh_cnt   <= '0;
        end else if (done_q) begin
            refresh_armed <= 1'b1;
            refresh_cnt   <= 32'd1;
        end else if (refresh_armed) begin
            refresh_cnt <= refresh_cnt + 32'd1;
        end
    end
`else
    assign start_req = bus.start_frame;
`endif

    assign tx_valid = (state == S_INIT) || (state == S_SET_Y) || (state == S_SET_X) ||
                      ((state == S_DATA) && captured);
    assign tx_rs    = (state == S_DATA);
    assign tx_fire  = tx_valid && tx_ready;

    always_comb begin
        tx_data = 8'h00;
        case (state)
            S_INIT:  tx_data = init_cmd(init_idx);
            S_SET_Y: tx_data = CMD_ADDR | 8'(line);
            S_SET_X: tx_data = CMD_ADDR;
            S_DATA:  tx_data = data_q;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            init_done <= 1'b0;
            init_idx  <= '0;
            line      <= '0;
            col       <= '0;
            data_q    <= '0;
            captured  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        busy_q   <= 1'b1;
                        line     <= '0;
                        col      <= '0;
                        init_idx <= '0;
                        state    <= init_done ? S_SET_Y : S_INIT;
                    end
                end
                S_INIT: begin
                    if (tx_fire) begin
                        if (init_idx == 2'd3) begin
                            init_done <= 1'b1;
                            state     <= S_SET_Y;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                S_SET_Y: if (tx_fire) state <= S_SET_X;
                S_SET_X: begin
                    if (tx_fire) begin
                        rd_en_q <= 1'b1;
                        addr_q  <= byte_addr(line, col);
                        state   <= S_FETCH;
                    end
                end
                // Read strobe is high during this cycle; data arrives next cycle
                S_FETCH: begin
                    captured <= 1'b0;
                    state    <= S_DATA;
                end
                S_DATA: begin
                    if (!captured) begin
                        data_q   <= bus.fb_rd_data;
                        captured <= 1'b1;
                    end else if (tx_fire) begin
                        if (col == BPL_LAST) begin
                            col <= '0;
                            if (line == LINE_LAST) begin
                                line  <= '0;
                                state <= S_FLUSH;
                            end else begin
                                line  <= line + 1'b1;
                                state <= S_SET_Y;
                            end
                        end else begin
                            // Prefetch the next byte while the shifter is busy
                            col     <= col + 1'b1;
                            rd_en_q <= 1'b1;
                            addr_q  <= byte_addr(line, col + 1'b1);
                            state   <= S_FETCH;
                        end
                    end
                end
                // Frame counts as complete only once the last byte and its gap are out
                S_FLUSH: begin
                    if (tx_ready) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.fb_rd_en   = rd_en_q;
    assign bus.fb_addr    = addr_q;

    st7920_serial_tx #(
        .CLK_DIV     (CLK_DIV),
        .CMD_GAP_CYC (CMD_GAP_CYC)
    ) u_tx (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_rs    (tx_rs),
        .tx_data  (tx_data),
        .lcd_cs   (bus.lcd_cs),
        .lcd_sclk (bus.lcd_sclk),
        .lcd_sid  (bus.lcd_sid)
    );

endmodule

`default_nettype wire

// File: tb/tb_st7920_gfx_streamer.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_st7920_gfx_streamer                                          |
// | Purpose  : Scoreboard bench: stimulus pushes expected {rs,byte} words,     |
// |            a serial decoder pops and compares each received frame.         |
// |            Instance a: FOLD=1, ROWS=4; instance b: FOLD=0, ROWS=2;         |
// |            instance c (ST7920_AUTO_REFRESH_EN only): REFRESH_CYC=50.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_st7920_gfx_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    st7920_gfx_streamer_if #(.FB_AW(3)) ifa ();
    st7920_gfx_streamer_if #(.FB_AW(2)) ifb ();

    st7920_gfx_streamer #(.CLK_DIV(2), .CMD_GAP_CYC(4), .COLS_BYTES(2), .ROWS(4), .FOLD(1))
        dut_a (.sys_clk(clk), .sys_rst(rst), .bus(ifa));
    st7920_gfx_streamer #(.CLK_DIV(2), .CMD_GAP_CYC(4), .COLS_BYTES(2), .ROWS(2), .FOLD(0))
        dut_b (.sys_clk(clk), .sys_rst(rst), .bus(ifb));

`ifdef ST7920_AUTO_REFRESH_EN
    st7920_gfx_streamer_if #(.FB_AW(3)) ifc ();
    st7920_gfx_streamer #(.CLK_DIV(2), .CMD_GAP_CYC(4), .COLS_BYTES(2), .ROWS(4), .FOLD(1),
                          .REFRESH_CYC(50))
        dut_c (.sys_clk(clk), .sys_rst(rst), .bus(ifc));
    int  done_c = 0;
    int  done_cyc_c = 0;
    int  rise_cyc_c = 0;
    logic pbusy_c = 1'b0;
    always @(posedge clk) ifc.fb_rd_data <= ifc.fb_rd_en ? 8'(ifc.fb_addr) : 8'hEE;
    always @(negedge clk) begin
        if (ifc.frame_done) begin done_c++; done_cyc_c = cyc; end
        if (ifc.busy && !pbusy_c) rise_cyc_c = cyc;
        pbusy_c = ifc.busy;
    end
`endif

    // Framebuffer models: fb[i] = i, data valid exactly one cycle after the strobe
    always @(posedge clk) begin
        ifa.fb_rd_data <= ifa.fb_rd_en ? 8'(ifa.fb_addr) : 8'hEE;
        ifb.fb_rd_data <= ifb.fb_rd_en ? 8'(ifb.fb_addr) : 8'hEE;
    end

    // Expected streams as {rs, byte}
    localparam logic [8:0] EXP_INIT [4]  = '{9'h030, 9'h00C, 9'h034, 9'h036};
    localparam logic [8:0] EXP_A    [12] = '{9'h080, 9'h080, 9'h100, 9'h101, 9'h104, 9'h105,
                                             9'h081, 9'h080, 9'h102, 9'h103, 9'h106, 9'h107};
    localparam logic [8:0] EXP_B    [8]  = '{9'h080, 9'h080, 9'h100, 9'h101,
                                             9'h081, 9'h080, 9'h102, 9'h103};
    localparam int CMD_CYC = 48 * 2 + 4 + 2;
    localparam int CS_HIGH = 1 + 48 * 2;

    logic [8:0] exp_a [$];
    logic [8:0] exp_b [$];

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    task automatic check_range(input string nm, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("FAIL %s got=%0d expected=[%0d..%0d]", nm, got, lo, hi);
        end
    endtask

    task automatic push_exp(input int id, input bit with_init);
        if (with_init) begin
            for (int i = 0; i < 4; i++) begin
                if (id == 0) exp_a.push_back(EXP_INIT[i]); else exp_b.push_back(EXP_INIT[i]);
            end
        end
        if (id == 0) begin
            for (int i = 0; i < 12; i++) exp_a.push_back(EXP_A[i]);
        end else begin
            for (int i = 0; i < 8; i++) exp_b.push_back(EXP_B[i]);
        end
    endtask

    // ---------------- serial decoder / monitor ----------------
    logic [23:0] sh     [2] = '{24'h0, 24'h0};
    int          nbits  [2] = '{0, 0};
    int          hi_len [2] = '{0, 0};
    logic        pcs    [2] = '{1'b0, 1'b0};
    logic        psclk  [2] = '{1'b0, 1'b0};
    logic        psid   [2] = '{1'b0, 1'b0};
    int          viol = 0;
    int          done_n   [2] = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    int          rise_cyc [2] = '{0, 0};
    logic        pbusy    [2] = '{1'b0, 1'b0};

    task automatic mon_step(input int id, input logic cs, input logic sclk, input logic sid);
        logic [23:0] f;
        logic [8:0]  got;
        logic [8:0]  exp;
        string       nm;
        nm = (id == 0) ? "a" : "b";
        if (cs && !pcs[id]) begin nbits[id] = 0; hi_len[id] = 0; end
        if (cs) hi_len[id]++;
        if (cs && sclk && !psclk[id]) begin
            sh[id] = {sh[id][22:0], sid};
            nbits[id]++;
        end
        // Partial frames (reset abort) are dropped silently
        if (!cs && pcs[id] && nbits[id] == 24) begin
            f = sh[id];
            check({nm, "_fmt"}, int'({f[23:18], f[16], f[11:8], f[3:0]}), int'(15'b111110_0_0000_0000));
            check({nm, "_cs_len"}, hi_len[id], CS_HIGH);
            got = {f[17], f[15:12], f[7:4]};
            if ((id == 0 && exp_a.size() == 0) || (id == 1 && exp_b.size() == 0)) begin
                checks++;
                failures++;
                $display("FAIL %s_seq_extra got=0x%03h expected=none", nm, got);
            end else begin
                exp = (id == 0) ? exp_a.pop_front() : exp_b.pop_front();
                check({nm, "_seq"}, int'(got), int'(exp));
            end
        end
        if (!cs && !pcs[id] && sclk != psclk[id]) viol++;
        if (sclk && psclk[id] && sid != psid[id]) viol++;
        pcs[id]   = cs;
        psclk[id] = sclk;
        psid[id]  = sid;
    endtask

    always @(negedge clk) begin
        mon_step(0, ifa.lcd_cs, ifa.lcd_sclk, ifa.lcd_sid);
        mon_step(1, ifb.lcd_cs, ifb.lcd_sclk, ifb.lcd_sid);
        if (ifa.frame_done) begin done_n[0]++; done_cyc[0] = cyc; end
        if (ifb.frame_done) begin done_n[1]++; done_cyc[1] = cyc; end
        if (ifa.busy && !pbusy[0]) rise_cyc[0] = cyc;
        if (ifb.busy && !pbusy[1]) rise_cyc[1] = cyc;
        pbusy[0] = ifa.busy;
        pbusy[1] = ifb.busy;
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input int id);
        @(negedge clk);
        if (id == 0) ifa.start_frame = 1'b1; else ifb.start_frame = 1'b1;
        @(negedge clk);
        if (id == 0) ifa.start_frame = 1'b0; else ifb.start_frame = 1'b0;
    endtask

    task automatic wait_done(input int id, input int target, input int limit);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_n[id] >= target) begin hit = 1'b1; break; end
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL timeout_%0d got=%0d expected=%0d", id, done_n[id], target);
        end
    endtask

    function automatic int outs_a();
        return int'({ifa.busy, ifa.frame_done, ifa.fb_rd_en, ifa.fb_addr,
                     ifa.lcd_cs, ifa.lcd_sclk, ifa.lcd_sid});
    endfunction

    function automatic int outs_b();
        return int'({ifb.busy, ifb.frame_done, ifb.fb_rd_en, ifb.fb_addr,
                     ifb.lcd_cs, ifb.lcd_sclk, ifb.lcd_sid});
    endfunction

    initial begin
        ifa.start_frame = 1'b0;
        ifb.start_frame = 1'b0;
`ifdef ST7920_AUTO_REFRESH_EN
        ifc.start_frame = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("a_reset_outs", outs_a(), 0);
        check("b_reset_outs", outs_b(), 0);
        rst = 1'b0;

        // Frame 1: init + full folded frame, 16 commands back to back
        push_exp(0, 1'b1);
        pulse(0);
        wait_done(0, 1, 4000);
        check("a_done_cnt1", done_n[0], 1);
        check_range("a_frame_cycles", done_cyc[0] - rise_cyc[0], 16 * CMD_CYC, 16 * CMD_CYC + 40);

        // Frame 2: no init; a start pulse mid-frame must be ignored
        push_exp(0, 1'b0);
        pulse(0);
        repeat (400) @(negedge clk);
        check("a_busy_mid", int'(ifa.busy), 1);
        pulse(0);
        wait_done(0, 2, 4000);
        repeat (300) @(negedge clk);
        check("a_done_cnt2", done_n[0], 2);
        check("a_busy_after", int'(ifa.busy), 0);
        check("a_queue_empty2", exp_a.size(), 0);

        // Frame 3: reset during the second command aborts the frame
        push_exp(0, 1'b0);
        pulse(0);
        repeat (150) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("a_reset_mid_outs", outs_a(), 0);
        exp_a.delete();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("a_done_cnt3", done_n[0], 2);

        // Frame 4: init must be re-sent after reset
        push_exp(0, 1'b1);
        pulse(0);
        wait_done(0, 3, 4000);
        check("a_done_cnt4", done_n[0], 3);
        check("a_queue_empty4", exp_a.size(), 0);

        // Unfolded instance: init + 8 bytes/commands
        push_exp(1, 1'b1);
        pulse(1);
        wait_done(1, 1, 3000);
        check("b_done_cnt", done_n[1], 1);
        check_range("b_frame_cycles", done_cyc[1] - rise_cyc[1], 12 * CMD_CYC, 12 * CMD_CYC + 40);
        check("b_queue_empty", exp_b.size(), 0);

        check("protocol_violations", viol, 0);

`ifdef ST7920_AUTO_REFRESH_EN
        @(negedge clk);
        ifc.start_frame = 1'b1;
        @(negedge clk);
        ifc.start_frame = 1'b0;
        for (int i = 0; i < 4000 && done_c < 1; i++) @(negedge clk);
        check("c_done_cnt", done_c, 1);
        for (int i = 0; i < 200 && rise_cyc_c <= done_cyc_c; i++) @(negedge clk);
        // auto start issued 50 cycles after frame_done, busy one cycle later
        check("c_refresh_delay", rise_cyc_c - done_cyc_c, 51);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/st7920_gfx_streamer.md
Name: st7920_gfx_streamer

Overview:
Parametrised successor to the single-purpose ST7920 serial driver. Streams a whole framebuffer from a synchronous-read memory port to an ST7920-class graphic LCD over the 3-wire serial interface (CS/SCLK/SID).
- Runs the init sequence only on the first frame after reset.
- Handles GDRAM row folding for tall panels.
- Provides a start/busy/done handshake to the owning controller.
- Sits between the framebuffer RAM and the LCD pins.

Parameters:
CLK_DIV, 256, sys_clk cycles per SCLK half-period (≥1)
CMD_GAP_CYC, 1024, idle sys_clk cycles after each 24-bit frame (CS low)
COLS_BYTES, 16, bytes per pixel row
ROWS, 64, pixel rows; must be even when FOLD=1
FOLD, 1, 1: row r+ROWS/2 is appended to GDRAM line r; 0: one pixel row per GDRAM line
Derived (localparam): LINES = FOLD ? ROWS/2 : ROWS; FB_AW = clog2(ROWS*COLS_BYTES)

Ports:
sys_clk  in  1  only clock
sys_rst  in  1  synchronous, active-high reset
start_frame  in  1  pulse; request one full-frame refresh
busy  out  1  high from accepted start until frame complete
frame_done  out  1  one-cycle pulse at frame completion
fb_rd_en  out  1  framebuffer read strobe
fb_addr  out  FB_AW  byte address = row*COLS_BYTES + col
fb_rd_data  in  8  read data, valid exactly 1 cycle after fb_rd_en
lcd_cs  out  1  chip select, active high
lcd_sclk  out  1  serial clock, idles low
lcd_sid  out  1  serial data

Behaviour:
- Reset: all outputs 0, FSM in IDLE, init_done cleared. The next frame re-runs init. Reset mid-frame aborts immediately: CS drops, no partial frame is completed.
- Serial frame format: 24 bits, MSB first: 11111, RW=0, RS, 0, D7..D4, 0000, D3..D0, 0000.
  - RS=0 for commands, 1 for data.
- Bit timing:
  - SID changes only while SCLK is low.
  - SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles, per bit.
  - CS rises one cycle before the first low phase and falls after the last high phase.
  - The gap of CMD_GAP_CYC cycles follows with CS=0.
  - One command therefore takes 48*CLK_DIV + CMD_GAP_CYC + 2 sys_clk cycles.
- FSM states: IDLE → INIT (if !init_done) → SET_Y → SET_X → FETCH → DATA → (next byte: FETCH | next line: SET_Y | end: DONE) → IDLE.
  - INIT sends 0x30, 0x0C, 0x34, 0x36, then sets init_done.
  - SET_Y sends 0x80|line. SET_X sends 0x80.
  - FETCH pulses fb_rd_en for one cycle. Data is captured on the following cycle, and DATA launches the serial frame.
- Byte order per line:
  - FOLD=1: bytes col 0..COLS_BYTES-1 of row `line`, then the same columns of row `line`+ROWS/2 (2*COLS_BYTES bytes).
  - FOLD=0: COLS_BYTES bytes of row `line`.
- Handshake:
  - start_frame is accepted only in IDLE. It is ignored while busy (no queueing).
  - busy rises the cycle after acceptance.
  - In DONE: frame_done=1 and busy=0 for one cycle. The FSM is in IDLE the next cycle, and start_frame is accepted from that cycle.
- fb_addr holds its last value between reads. Address arithmetic is in FB_AW bits; line counter and column counter wrap cleanly at LINES/bytes-per-line with no overflow.

Optional Feature:
ST7920_AUTO_REFRESH_EN
- Defined:
  - Adds parameter REFRESH_CYC (default 2_000_000).
  - A free-running counter self-issues start_frame REFRESH_CYC cycles after each frame_done.
  - An external start_frame still works and restarts the counter.
  - Reset clears the counter.
- Undefined: frames start only on external start_frame; no counter logic.

Decomposition:
- Package st7920_pkg:
  - FSM state enum.
  - Command constants CMD_FUNC_BASIC=0x30, CMD_DISP_ON=0x0C, CMD_FUNC_EXT=0x34, CMD_GFX_ON=0x36, CMD_ADDR=0x80.
  - Sync header 5'b11111.
  - Function building the 24-bit frame from {rs, data}.
- Sub-module st7920_serial_tx:
  - Interface: tx_valid/tx_ready/tx_rs/tx_data in, lcd_cs/lcd_sclk/lcd_sid out.
  - Owns bit timing and the gap.
  - tx_ready is high only in its idle state.

Test Plan:
- Params CLK_DIV=2, CMD_GAP_CYC=4, COLS_BYTES=2, ROWS=4, FOLD=1; fb[i]=i; one start_frame.
  - Decoded SPI sequence must be: 30,0C,34,36, 80,80,D00,D01,D04,D05, 81,80,D02,D03,D06,D07.
  - frame_done fires exactly once, 16*(96+4+2)+FSM overhead cycles after start.
- Second start_frame after frame_done: no INIT commands; the first decoded byte is 0x80.
- start_frame pulsed while busy: ignored; the decoded stream and frame_done count are unchanged.
- sys_rst asserted mid-byte: next cycle all outputs are 0. A following start_frame re-sends 0x30 first.
- FOLD=0, ROWS=2: decoded 80,80,D00,D01,81,80,D02,D03. No SCLK edge while CS is low; SID is stable while SCLK is high.
- With ST7920_AUTO_REFRESH_EN, REFRESH_CYC=50: the second frame starts exactly 50 cycles after the first frame_done, with no external start.
